// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scancode constants, byte classes and parser states
// Contents:
//   SC_*        set-2 make codes used by the move decoder
//   ps2_cls_e   classification of a single scancode byte
//   ps2_state_e prefix parser state (idle, E0 seen, F0 seen)
package ps2_pkg;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_R     = 8'h2D;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   localparam logic [7:0] SC_A = 8'h1C;
   localparam logic [7:0] SC_B = 8'h32;
   localparam logic [7:0] SC_C = 8'h21;
   localparam logic [7:0] SC_D = 8'h23;
   localparam logic [7:0] SC_E = 8'h24;
   localparam logic [7:0] SC_F = 8'h2B;
   localparam logic [7:0] SC_G = 8'h34;
   localparam logic [7:0] SC_H = 8'h33;

   localparam logic [7:0] SC_1 = 8'h16;
   localparam logic [7:0] SC_2 = 8'h1E;
   localparam logic [7:0] SC_3 = 8'h26;
   localparam logic [7:0] SC_4 = 8'h25;
   localparam logic [7:0] SC_5 = 8'h2E;
   localparam logic [7:0] SC_6 = 8'h36;
   localparam logic [7:0] SC_7 = 8'h3D;
   localparam logic [7:0] SC_8 = 8'h3E;

   typedef enum logic [3:0] {
      CLS_LETTER,
      CLS_DIGIT,
      CLS_LEFT,
      CLS_RIGHT,
      CLS_R,
      CLS_BKSP,
      CLS_ESC,
      CLS_E0,
      CLS_F0,
      CLS_OTHER
   } ps2_cls_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK
   } ps2_state_e;

endpackage

// File: rtl/ps2_scancode_classify.sv
// ps2_scancode_classify: combinational scancode byte to {class, 3-bit value}
// Ports:
//   i_byte  scancode byte
//   o_cls   byte class
//   o_val   file (letters A-H) or rank (digits 1-8) as 0-7, else 0
module ps2_scancode_classify
   import ps2_pkg::*;
(
   input  logic [7:0] i_byte,
   output ps2_cls_e   o_cls,
   output logic [2:0] o_val
);

   always_comb begin
      o_cls = CLS_OTHER;
      o_val = 3'd0;
      case (i_byte)
         SC_A:     begin o_cls = CLS_LETTER; o_val = 3'd0; end
         SC_B:     begin o_cls = CLS_LETTER; o_val = 3'd1; end
         SC_C:     begin o_cls = CLS_LETTER; o_val = 3'd2; end
         SC_D:     begin o_cls = CLS_LETTER; o_val = 3'd3; end
         SC_E:     begin o_cls = CLS_LETTER; o_val = 3'd4; end
         SC_F:     begin o_cls = CLS_LETTER; o_val = 3'd5; end
         SC_G:     begin o_cls = CLS_LETTER; o_val = 3'd6; end
         SC_H:     begin o_cls = CLS_LETTER; o_val = 3'd7; end
         SC_1:     begin o_cls = CLS_DIGIT;  o_val = 3'd0; end
         SC_2:     begin o_cls = CLS_DIGIT;  o_val = 3'd1; end
         SC_3:     begin o_cls = CLS_DIGIT;  o_val = 3'd2; end
         SC_4:     begin o_cls = CLS_DIGIT;  o_val = 3'd3; end
         SC_5:     begin o_cls = CLS_DIGIT;  o_val = 3'd4; end
         SC_6:     begin o_cls = CLS_DIGIT;  o_val = 3'd5; end
         SC_7:     begin o_cls = CLS_DIGIT;  o_val = 3'd6; end
         SC_8:     begin o_cls = CLS_DIGIT;  o_val = 3'd7; end
         SC_LEFT:  o_cls = CLS_LEFT;
         SC_RIGHT: o_cls = CLS_RIGHT;
         SC_R:     o_cls = CLS_R;
         SC_BKSP:  o_cls = CLS_BKSP;
         SC_ESC:   o_cls = CLS_ESC;
         SC_E0:    o_cls = CLS_E0;
         SC_F0:    o_cls = CLS_F0;
         default:  ;
      endcase
   end

endmodule

// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder: PS/2 scancode stream to board-square and command register writes
// Ports:
//   clock, reset (async active-low)
//   ps2_key_data/ps2_key_pressed    scancode byte and its one-cycle strobe
//   keyboard_we/_write_data/_write_address  registered one-cycle write port
//   slot_sel                        current destination slot
//   have_letter/have_number         partial-entry status
module ps2_move_decoder
   import ps2_pkg::*;
#(
   parameter int                NUM_SLOTS = 2,
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 12'd64,
   parameter logic [ADDR_W-1:0] CMD_ADDR  = 12'd67,
   localparam int               SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        ps2_key_data,
   input  logic              ps2_key_pressed,
   output logic              keyboard_we,
   output logic [DATA_W-1:0] keyboard_write_data,
   output logic [ADDR_W-1:0] keyboard_write_address,
   output logic [SLOT_W-1:0] slot_sel,
   output logic              have_letter,
   output logic              have_number
);

   localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_SLOTS - 1);

   ps2_cls_e          w_cls;
   logic [2:0]        w_val;
   logic              w_make;
   logic [ADDR_W-1:0] w_slot_addr;

   ps2_state_e        r_state;
   logic [7:0]        r_last_make;
   logic [2:0]        r_file;
   logic [2:0]        r_rank;
   logic              r_have_letter;
   logic              r_have_number;
   logic              r_last_was_letter;
   logic [SLOT_W-1:0] r_slot;
   logic              r_we;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] r_addr;

   ps2_scancode_classify u_classify (
      .i_byte (ps2_key_data),
      .o_cls  (w_cls),
      .o_val  (w_val)
   );

   // A make byte is acted on only outside a break sequence, when it is not a
   // prefix, and when it differs from the held key (typematic repeats dropped).
   assign w_make = ps2_key_pressed && r_state != ST_BRK && w_cls != CLS_F0 &&
                   w_cls != CLS_E0 && ps2_key_data != r_last_make;
   assign w_slot_addr = BASE_ADDR + ADDR_W'(r_slot);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state           <= ST_IDLE;
         r_last_make       <= 8'h00;
         r_file            <= 3'd0;
         r_rank            <= 3'd0;
         r_have_letter     <= 1'b0;
         r_have_number     <= 1'b0;
         r_last_was_letter <= 1'b0;
         r_slot            <= '0;
         r_we              <= 1'b0;
         r_data            <= '0;
         r_addr            <= BASE_ADDR;
      end else begin
         r_we <= 1'b0;
         if (ps2_key_pressed) begin
            // E0 E0 falls through to IDLE: a repeated prefix is treated as noise.
            r_state <= (r_state == ST_BRK) ? ST_IDLE :
                       (w_cls == CLS_F0) ? ST_BRK :
                       (w_cls == CLS_E0 && r_state == ST_IDLE) ? ST_EXT : ST_IDLE;
            if (r_state == ST_BRK && ps2_key_data == r_last_make)
               r_last_make <= 8'h00;
         end
         if (w_make) begin
            r_last_make <= ps2_key_data;
            case (w_cls)
               CLS_LETTER: begin
                  r_file            <= w_val;
                  r_last_was_letter <= 1'b1;
                  r_have_letter     <= !r_have_number;
                  r_have_number     <= 1'b0;
                  if (r_have_number) begin
                     r_we   <= 1'b1;
                     r_addr <= w_slot_addr;
                     r_data <= DATA_W'({r_rank, w_val});
                  end
               end
               CLS_DIGIT: begin
                  r_rank            <= w_val;
                  r_last_was_letter <= 1'b0;
                  r_have_number     <= !r_have_letter;
                  r_have_letter     <= 1'b0;
                  if (r_have_letter) begin
                     r_we   <= 1'b1;
                     r_addr <= w_slot_addr;
                     r_data <= DATA_W'({w_val, r_file});
                  end
               end
               CLS_LEFT: begin
                  r_slot        <= (r_slot == '0) ? r_slot : r_slot - 1'b1;
                  r_have_letter <= 1'b0;
                  r_have_number <= 1'b0;
               end
               CLS_RIGHT: begin
                  r_slot        <= (r_slot == SLOT_MAX) ? r_slot : r_slot + 1'b1;
                  r_have_letter <= 1'b0;
                  r_have_number <= 1'b0;
               end
               CLS_BKSP: begin
                  // Only one flag can be pending at a time; drop the newest one.
                  if (r_last_was_letter) r_have_letter <= 1'b0;
                  else                   r_have_number <= 1'b0;
               end
               CLS_ESC: begin
                  r_slot        <= '0;
                  r_have_letter <= 1'b0;
                  r_have_number <= 1'b0;
               end
               CLS_R: begin
                  r_we          <= 1'b1;
                  r_addr        <= CMD_ADDR;
                  r_data        <= DATA_W'(1);
                  r_have_letter <= 1'b0;
                  r_have_number <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign keyboard_we            = r_we;
   assign keyboard_write_data    = r_data;
   assign keyboard_write_address = r_addr;
   assign slot_sel               = r_slot;
   assign have_letter            = r_have_letter;
   assign have_number            = r_have_number;

endmodule

// File: doc/ps2_move_decoder.md
# ps2_move_decoder

Parametrised successor to the single-square keyboard front end: turns the PS/2 scancode byte stream into board-coordinate and command writes for the chess processor's memory-mapped input registers. Fully synchronous to `clock`, with break-code (F0) and extended-prefix (E0) parsing. Adds typematic-repeat suppression, an N-slot cursor, backspace/escape editing and one-cycle registered write pulses. Sits between the PS/2 controller and the data-memory write mux.

## Interface
- `NUM_SLOTS`, 2: number of coordinate destination registers; left/right arrows select among them.
- `BASE_ADDR`, 12'd64: address of slot 0; slot k writes to `BASE_ADDR + k`.
- `CMD_ADDR`, 12'd67: address written on the reset-game command.
- `ADDR_W`, 12: address width.
- `DATA_W`, 32: write-data width (>= 6).
- `clock`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_key_data`  in  8  scancode byte from the PS/2 controller.
- `ps2_key_pressed`  in  1  one-cycle strobe, synchronous to `clock`: `ps2_key_data` valid this cycle.
- `keyboard_we`  out  1  one-cycle write strobe.
- `keyboard_write_data`  out  DATA_W  write data, zero-extended.
- `keyboard_write_address`  out  ADDR_W  write address.
- `slot_sel`  out  max(1,$clog2(NUM_SLOTS))  current destination slot.
- `have_letter`, `have_number`  out  1 each  partial-entry status for on-screen cursor.

## Operation
- Byte classes: letter A–H = 1C,32,21,23,24,2B,34,33 → file 0–7; digit 1–8 = 16,1E,26,25,2E,36,3D,3E → rank 0–7; left 6B; right 74; `r` 2D; backspace 66; escape 76; prefixes E0 and F0; all else = other.
- Parser FSM: `IDLE`, `EXT` (E0 seen), `BRK` (F0 seen, with or without preceding E0).
  - E0 in IDLE → EXT. F0 in IDLE or EXT → BRK. Any other byte → classify, act as below, return to IDLE.
  - In BRK, the next byte is a release: it is not acted on. If it equals `last_make`, clear `last_make`. Return to IDLE.
- Repeat suppression: a make byte equal to `last_make` is ignored (typematic). Otherwise record it in `last_make`, then act.
- Arrows are accepted with or without E0 prefix.
- Actions:
  - Letter: store file, set `have_letter`; a second letter overwrites.
  - Digit: store rank, set `have_number`; same overwrite rule.
  - When both flags become set: write data = {0…, rank[2:0], file[2:0]} to `BASE_ADDR + slot_sel`; clear both flags.
  - Left/right: `slot_sel` decrements/increments, saturating at 0 and `NUM_SLOTS-1`; clear partial entry.
  - Backspace: clear the most recently set flag only. Hold a 1-bit `last_was_letter`; no-op if both flags are clear.
  - Escape: clear both flags, `slot_sel` ← 0.
  - `r`: write 1 to `CMD_ADDR`, clear partial entry; `slot_sel` unchanged.
  - Other/E0 followed by an unclassified byte: ignored, FSM to IDLE.
- Entry is order-independent: letter-then-digit and digit-then-letter both complete a square.

## Timing
- Strobe in cycle N → state update and `keyboard_we`=1 with valid address/data in cycle N+1; we held exactly one cycle.
- Address/data registered and held after a write until the next write; not meaningful while we=0.
- A strobe arriving in the cycle `keyboard_we` is high is processed normally. Back-to-back strobes yield back-to-back writes.
- No strobe → no state change.
- Reset (async assert, sync release): `keyboard_we`=0, data=0, address=`BASE_ADDR`, `slot_sel`=0, flags=0, `last_make`=00, FSM IDLE.
- Reset mid-sequence (e.g. after F0) discards the pending byte context.

## Structure
- Package `ps2_pkg`: scancode localparams, byte-class enum {CLS_LETTER, CLS_DIGIT, CLS_LEFT, CLS_RIGHT, CLS_R, CLS_BKSP, CLS_ESC, CLS_E0, CLS_F0, CLS_OTHER}, parser state enum.
- Sub-module `ps2_scancode_classify`: combinational byte → {class, 3-bit value}; reusable by other keyboard consumers.
- Top: parser FSM, repeat filter, entry registers, slot counter, registered write port.

## Test plan
- Strobes 1C, 1E (A, 2) → one write cycle N+1 after 1E: addr 64, data 32'h08 (rank 1, file 0); flags cleared.
- 74, then 3E, F0, 3E, 33 (right, 8 make/break, H) → `slot_sel`=1; addr 65, data 32'h3F.
- 1C, 1C, 1C, F0, 1C, 16 → letter stored once; single write addr 64 data 32'h00; `last_make` cleared by release.
- 2D, 2D, F0, 2D, 2D → exactly two writes to addr 67 data 1.
- 24, 66, 32, 36 → backspace drops E; write addr 64 data {rank 5, file 1} = 32'h29. Also test E0 6B at slot 0 → stays 0, and 76 → slot 0.
- Assert `reset` low after 1C, F0 → all outputs at reset values; next 16 sets only `have_number`, no write.
